// File: rtl/hs_fifo_pkt_sfifo_if.sv
// Handshake bundle for the packet FIFO: write stream in, read stream out, plus status.
// The FIFO takes the slave side and the stream endpoints take the master side.
interface hs_fifo_pkt_sfifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wdrop;
  logic                  walmost_full;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  rpeek;
  logic                  ralmost_empty;
  logic [LW-1:0]         level;
  logic                  pkt_drop;

  modport slave (
    input  wvalid, wdata, wlast, wdrop, rready, rpeek,
    output wready, walmost_full, rvalid, rdata, rlast, ralmost_empty, level, pkt_drop
  );

  modport master (
    output wvalid, wdata, wlast, wdrop, rready, rpeek,
    input  wready, walmost_full, rvalid, rdata, rlast, ralmost_empty, level, pkt_drop
  );
endinterface

// File: rtl/hs_fifo_pkt_sfifo.sv
// Synchronous packet FIFO: packets become readable only once their last beat commits,
// can be dropped while in flight, and can be replayed on the read side with rpeek.
module hs_fifo_pkt_sfifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 1,
  parameter int PKT_MODE   = 1
) (
  input  logic                 clk,
  input  logic                 srst,
  hs_fifo_pkt_sfifo_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

  typedef enum logic [1:0] {W_IDLE, W_IN_PKT, W_DISCARD} wstate_e;

  wstate_e          wstate_q, wstate_d;
  logic [PW-1:0]    wp_spec_q, wp_spec_d;
  logic [PW-1:0]    wp_cmt_q, wp_cmt_d;
  logic [PW-1:0]    rp_rd_q, rp_rd_d;
  logic [PW-1:0]    rp_rel_q, rp_rel_d;
  logic [PW-1:0]    rp_pkt_q, rp_pkt_d;
  logic [PW-1:0]    pkt_len_q, pkt_len_d;
  logic             pkt_drop_q, pkt_drop_d;
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;

  logic [PW-1:0]    level_w;
  logic [PW-1:0]    unread_w;
  logic             drop_req;
  logic             wready_w;
  logic             rvalid_w;
  logic [DATA_WIDTH:0] rword;

  assign level_w  = wp_spec_q - rp_rel_q;
  assign unread_w = wp_cmt_q - rp_rd_q;
  assign drop_req = (PKT_MODE != 0) && bus.wvalid && bus.wdrop && (wstate_q != W_DISCARD);
  // Drops and discarded beats never occupy storage, so they bypass the space check.
  assign wready_w = (wstate_q == W_DISCARD) || drop_req || (level_w < DEPTH_P);
  assign rvalid_w = rp_rd_q != wp_cmt_q;
  assign rword    = mem_q[rp_rd_q[AW-1:0]];

  assign bus.wready        = !srst && wready_w;
  assign bus.rvalid        = !srst && rvalid_w;
  assign bus.rdata         = rword[DATA_WIDTH-1:0];
  assign bus.rlast         = !srst && rvalid_w && rword[DATA_WIDTH];
  assign bus.level         = srst ? '0 : level_w;
  assign bus.walmost_full  = !srst && (level_w >= AF_P);
  assign bus.ralmost_empty = srst || (unread_w <= AE_P);
  assign bus.pkt_drop      = !srst && pkt_drop_q;

  always_comb begin
    wstate_d   = wstate_q;
    wp_spec_d  = wp_spec_q;
    wp_cmt_d   = wp_cmt_q;
    pkt_len_d  = pkt_len_q;
    pkt_drop_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wp_spec_q[AW-1:0];
    if (bus.wvalid && wready_w) begin
      if (wstate_q == W_DISCARD) begin
        if (bus.wlast) wstate_d = W_IDLE;
      end else if (drop_req) begin
        wp_spec_d  = wp_cmt_q;
        pkt_len_d  = '0;
        pkt_drop_d = 1'b1;
        wstate_d   = bus.wlast ? W_IDLE : W_DISCARD;
      end else begin
        mem_we    = 1'b1;
        wp_spec_d = wp_spec_q + 1'b1;
        if (PKT_MODE == 0) begin
          wp_cmt_d = wp_spec_q + 1'b1;
        end else if (bus.wlast) begin
          wp_cmt_d  = wp_spec_q + 1'b1;
          pkt_len_d = '0;
          wstate_d  = W_IDLE;
        end else if (pkt_len_q + 1'b1 == DEPTH_P) begin
          // Oversize: the word just written lands in free space and is abandoned.
          wp_spec_d  = wp_cmt_q;
          pkt_len_d  = '0;
          pkt_drop_d = 1'b1;
          wstate_d   = W_DISCARD;
        end else begin
          pkt_len_d = pkt_len_q + 1'b1;
          wstate_d  = W_IN_PKT;
        end
      end
    end
  end

  always_comb begin
    rp_rd_d  = rp_rd_q;
    rp_rel_d = rp_rel_q;
    rp_pkt_d = rp_pkt_q;
    if (rvalid_w && bus.rready) begin
      rp_rd_d = rp_rd_q + 1'b1;
      if (PKT_MODE == 0) begin
        rp_rel_d = rp_rd_q + 1'b1;
        rp_pkt_d = rp_rd_q + 1'b1;
      end else if (rword[DATA_WIDTH]) begin
        if (bus.rpeek) begin
          rp_rd_d = rp_pkt_q;
        end else begin
          rp_rel_d = rp_rd_q + 1'b1;
          rp_pkt_d = rp_rd_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wstate_q   <= W_IDLE;
      wp_spec_q  <= '0;
      wp_cmt_q   <= '0;
      rp_rd_q    <= '0;
      rp_rel_q   <= '0;
      rp_pkt_q   <= '0;
      pkt_len_q  <= '0;
      pkt_drop_q <= 1'b0;
    end else begin
      wstate_q   <= wstate_d;
      wp_spec_q  <= wp_spec_d;
      wp_cmt_q   <= wp_cmt_d;
      rp_rd_q    <= rp_rd_d;
      rp_rel_q   <= rp_rel_d;
      rp_pkt_q   <= rp_pkt_d;
      pkt_len_q  <= pkt_len_d;
      pkt_drop_q <= pkt_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !srst) mem_q[mem_waddr] <= {bus.wlast, bus.wdata};
  end
endmodule

// File: tb/tb_hs_fifo_pkt_sfifo.sv
// Randomised bench for the packet FIFO, with a queue-based reference model that tracks
// committed packets, the partial packet, replay position and drops for both modes.
module tb_hs_fifo_pkt_sfifo;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int AF = D - 2;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  hs_fifo_pkt_sfifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) pb();
  hs_fifo_pkt_sfifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) mb();

  hs_fifo_pkt_sfifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .PKT_MODE(1))
    dut (.clk(clk), .srst(srst), .bus(pb));
  hs_fifo_pkt_sfifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .PKT_MODE(0))
    dut0 (.clk(clk), .srst(srst), .bus(mb));

  int checks = 0;
  int errors = 0;
  bit done0 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-mode model: committed unreleased words, the speculative packet and read position.
  logic [DW:0] words[$];
  logic [DW:0] cur[$];
  logic [DW:0] hw;
  int  pos = 0;
  bit  disc = 1'b0;
  bit  drop_exp = 1'b0;
  int  occ;
  bit  exp_wready;
  int  npop;

  always @(negedge clk) begin
    if (srst) begin
      check("rst_wready", 32'(pb.wready), 0);
      check("rst_rvalid", 32'(pb.rvalid), 0);
      check("rst_rlast", 32'(pb.rlast), 0);
      check("rst_level", 32'(pb.level), 0);
      check("rst_walmost_full", 32'(pb.walmost_full), 0);
      check("rst_ralmost_empty", 32'(pb.ralmost_empty), 1);
      check("rst_pkt_drop", 32'(pb.pkt_drop), 0);
      words.delete(); cur.delete();
      pos = 0; disc = 1'b0; drop_exp = 1'b0;
    end else begin
      occ = words.size() + cur.size();
      exp_wready = disc || (pb.wvalid && pb.wdrop) || (occ < D);
      check("wready", 32'(pb.wready), 32'(exp_wready));
      check("level", 32'(pb.level), 32'(occ));
      check("walmost_full", 32'(pb.walmost_full), 32'(occ >= AF));
      check("rvalid", 32'(pb.rvalid), 32'(words.size() != 0));
      check("ralmost_empty", 32'(pb.ralmost_empty), 32'((words.size() - pos) <= AE));
      check("pkt_drop", 32'(pb.pkt_drop), 32'(drop_exp));
      drop_exp = 1'b0;
      if (words.size() != 0) begin
        hw = words[pos];
        check("rdata", 32'(pb.rdata), 32'(hw[DW-1:0]));
        check("rlast", 32'(pb.rlast), 32'(hw[DW]));
        if (pb.rready) begin
          if (hw[DW]) begin
            if (!pb.rpeek) begin
              npop = pos + 1;
              repeat (npop) void'(words.pop_front());
            end
            pos = 0;
          end else begin
            pos++;
          end
        end
      end
      if (pb.wvalid && exp_wready) begin
        if (disc) begin
          if (pb.wlast) disc = 1'b0;
        end else if (pb.wdrop) begin
          cur.delete();
          drop_exp = 1'b1;
          disc = !pb.wlast;
        end else begin
          cur.push_back({pb.wlast, pb.wdata});
          if (pb.wlast) begin
            foreach (cur[i]) words.push_back(cur[i]);
            cur.delete();
          end else if (cur.size() == D) begin
            cur.delete();
            drop_exp = 1'b1;
            disc = 1'b1;
          end
        end
      end
    end
  end

  // Plain-FIFO model for the PKT_MODE=0 instance.
  logic [DW:0] words0[$];
  logic [DW:0] hw0;
  bit  wr0;

  always @(negedge clk) begin
    if (srst) begin
      check("m0_rst_wready", 32'(mb.wready), 0);
      check("m0_rst_rvalid", 32'(mb.rvalid), 0);
      check("m0_rst_level", 32'(mb.level), 0);
      words0.delete();
    end else begin
      check("m0_wready", 32'(mb.wready), 32'(words0.size() < D));
      check("m0_rvalid", 32'(mb.rvalid), 32'(words0.size() != 0));
      check("m0_level", 32'(mb.level), 32'(words0.size()));
      check("m0_pkt_drop", 32'(mb.pkt_drop), 0);
      wr0 = mb.wvalid && (words0.size() < D);
      if (words0.size() != 0) begin
        hw0 = words0[0];
        check("m0_rdata", 32'(mb.rdata), 32'(hw0[DW-1:0]));
        check("m0_rlast", 32'(mb.rlast), 32'(hw0[DW]));
        if (mb.rready) void'(words0.pop_front());
      end
      if (wr0) words0.push_back({mb.wlast, mb.wdata});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input logic dr);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    pb.wvalid = 1'b1; pb.wdata = d; pb.wlast = l; pb.wdrop = dr;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = pb.wready;
      @(posedge clk); #1;
      n++;
    end
    pb.wvalid = 1'b0; pb.wlast = 1'b0; pb.wdrop = 1'b0;
    check("send_accept_timeout", 32'(acc), 1);
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) send(base + DW'(i), (i == len - 1), 1'b0);
  endtask

  initial begin
    srst = 1'b1;
    pb.wvalid = 0; pb.wdata = '0; pb.wlast = 0; pb.wdrop = 0; pb.rready = 0; pb.rpeek = 0;
    cyc(2);
    srst = 1'b0;
    // A,B,C then drain
    send_pkt(3, 8'hA0);
    cyc(1);
    pb.rready = 1'b1; cyc(5); pb.rready = 1'b0;
    // two beats then a dropping third
    send(8'h11, 0, 0); send(8'h12, 0, 0); send(8'h13, 0, 1);
    cyc(2);
    // oversize 10-beat packet, then an intact one
    send_pkt(10, 8'h20);
    send_pkt(2, 8'h40);
    pb.rready = 1'b1; cyc(4); pb.rready = 1'b0;
    // peek replay then release
    send_pkt(4, 8'h50);
    pb.rready = 1'b1; pb.rpeek = 1'b1; cyc(4);
    pb.rpeek = 1'b0; cyc(4); pb.rready = 1'b0;
    cyc(1);
    // fill, release one packet, drain
    send_pkt(4, 8'h60); send_pkt(4, 8'h70);
    pb.wvalid = 1'b1; pb.wdata = 8'hEE; cyc(2); pb.wvalid = 1'b0;
    pb.rready = 1'b1; cyc(4); pb.rready = 1'b0; cyc(2);
    pb.rready = 1'b1; cyc(6); pb.rready = 1'b0;
    // reset in the middle of a packet
    send(8'h81, 0, 0); send(8'h82, 0, 0);
    srst = 1'b1; cyc(1); srst = 1'b0; cyc(2);
    for (int c = 0; c < 3000; c++) begin
      pb.wvalid = ($urandom_range(0, 3) != 0);
      pb.wdata  = DW'($urandom);
      pb.wlast  = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
      pb.wdrop  = ($urandom_range(0, 19) == 0);
      pb.rready = ($urandom_range(0, 1) == 0);
      pb.rpeek  = ($urandom_range(0, 3) == 0);
      srst      = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    pb.wvalid = 0; pb.rready = 0; srst = 1'b0;
    wait (done0 == 1'b1);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    mb.wvalid = 0; mb.wdata = '0; mb.wlast = 0; mb.wdrop = 0; mb.rready = 0; mb.rpeek = 0;
    cyc(3);
    mb.wvalid = 1'b1; mb.wdata = 8'h5A; mb.wlast = 1'b0; cyc(1);
    mb.wdata = 8'hA5; mb.wdrop = 1'b1; cyc(1);
    mb.wvalid = 1'b0; mb.wdrop = 1'b0; cyc(1);
    mb.rready = 1'b1; cyc(3); mb.rready = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      mb.wvalid = ($urandom_range(0, 2) != 0);
      mb.wdata  = DW'($urandom);
      mb.wlast  = ($urandom_range(0, 3) == 0);
      mb.wdrop  = ($urandom_range(0, 4) == 0);
      mb.rready = ($urandom_range(0, 2) == 0);
      mb.rpeek  = ($urandom_range(0, 1) == 0);
      cyc(1);
    end
    mb.wvalid = 0; mb.rready = 0;
    done0 = 1'b1;
  end
endmodule
